// File: rtl/pool_window_if.sv
// pool_window_if: pixel-in / window-out stream handshake for the pooling window generator.
interface pool_window_if #(
  parameter int BITWIDTH = 8,
  parameter int SCALE    = 2
);
  logic                           in_valid;
  logic                           in_ready;
  logic [BITWIDTH-1:0]            in_data;
  logic                           out_valid;
  logic                           out_ready;
  logic [BITWIDTH*SCALE*SCALE-1:0] out_data;
  logic                           frame_done;
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, frame_done
  );
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, frame_done
  );
endinterface

// File: rtl/pool_window_gen.sv
// pool_window_gen: buffers SCALE-1 rows of a raster pixel stream and emits non-overlapping SCALExSCALE windows.
module pool_window_gen #(
  parameter int BITWIDTH = 8,
  parameter int SCALE    = 2,
  parameter int IMG_W    = 8,
  parameter int IMG_H    = 8
) (
  input logic         clk,
  input logic         rst_n,
  pool_window_if.slave s
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int SW = $clog2(SCALE);
  localparam int LD = (SCALE - 1) * IMG_W;
  localparam int AW = (LD > 1) ? $clog2(LD) : 1;
  localparam int OW = BITWIDTH * SCALE * SCALE;
  logic [CW-1:0]       col;
  logic [RW-1:0]       row;
  logic [SW-1:0]       wc, br;
  logic                out_valid;
  logic [OW-1:0]       out_data;
  logic                frame_done;
  logic [BITWIDTH-1:0] lb [LD];
  logic [BITWIDTH-1:0] acc [SCALE][SCALE];
  logic [BITWIDTH-1:0] colv [SCALE];
  logic [OW-1:0]       win_nxt;
  logic                accept, emit, last_col, last_row, win_done;
  assign s.in_ready   = !out_valid || s.out_ready;
  assign s.out_valid  = out_valid;
  assign s.out_data   = out_data;
  assign s.frame_done = frame_done;
  assign accept   = s.in_valid && s.in_ready;
  assign emit     = br == SW'(SCALE - 1);
  assign last_col = col == CW'(IMG_W - 1);
  assign last_row = row == RW'(IMG_H - 1);
  assign win_done = accept && emit && wc == SW'(SCALE - 1);
  // Current window column: buffered band rows above, live pixel at the bottom.
  for (genvar g = 0; g < SCALE; g++) begin : g_col
    if (g < SCALE - 1) begin : g_buf
      assign colv[g] = lb[AW'(g * IMG_W) + AW'(col)];
    end else begin : g_live
      assign colv[g] = s.in_data;
    end
  end
  always_comb begin
    win_nxt = '0;
    for (int r = 0; r < SCALE; r++)
      for (int c = 0; c < SCALE; c++)
        win_nxt[(r*SCALE+c)*BITWIDTH +: BITWIDTH] = (c == SCALE - 1) ? colv[r] : acc[r][c];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col        <= '0;
      row        <= '0;
      wc         <= '0;
      br         <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= accept && last_col && last_row;
      if (accept) begin
        col <= last_col ? '0 : col + 1'b1;
        wc  <= (wc == SW'(SCALE - 1)) ? '0 : wc + 1'b1;
        if (last_col) begin
          row <= last_row ? '0 : row + 1'b1;
          br  <= emit ? '0 : br + 1'b1;
        end
      end
      if (win_done) begin
        out_data  <= win_nxt;
        out_valid <= 1'b1;
      end else if (s.out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
  // Storage only: never observed until rewritten after reset, so no reset needed.
  always_ff @(posedge clk) begin
    if (accept && !emit)
      lb[AW'(br) * AW'(IMG_W) + AW'(col)] <= s.in_data;
    if (accept && emit)
      for (int r = 0; r < SCALE; r++)
        acc[r][wc] <= colv[r];
  end
endmodule
